// File: rtl/flag_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : flag_branch_unit
//  Brief    : Architectural flag register {sf,zf,cf,vf,pf} fed by the ALU,
//             plus a one-entry registered valid/ready stage that resolves
//             conditional branches against those flags for the fetch stage.
//  Options  : define FLAG_SAVE_EN to add a 5-bit shadow flag register with
//             save/restore ports.
//  Revision : 1.0  initial release
// ============================================================================
module flag_branch_unit #(
  parameter int         ADDR_W    = 32,
  parameter logic [4:0] FLAGS_RST = 5'b0,
  parameter bit         FWD       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_alu_valid,
  input  logic              i_alu_flag_up,
  input  logic [4:0]        i_alu_flags,
  input  logic              i_br_valid,
  output logic              o_br_ready,
  input  logic [3:0]        i_br_cond,
  input  logic [ADDR_W-1:0] i_br_target,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic              o_res_taken,
  output logic [ADDR_W-1:0] o_res_target,
`ifdef FLAG_SAVE_EN
  input  logic              i_flag_save,
  input  logic              i_flag_restore,
`endif
  output logic [4:0]        o_flags_out
);

  // Output stage occupancy
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [4:0]          r_flags;
  logic                r_res_taken;
  logic [ADDR_W-1:0]   r_res_target;
  logic                w_flag_wr;
  logic                w_fwd;
  logic                w_br_ready;
  logic                w_accept;
  logic                w_load;
  logic                w_taken;
  // Flags seen by condition evaluation, {sf,zf,cf,vf}; pf takes no part.
  logic [3:0]          w_eval;

  assign w_flag_wr = i_alu_valid & i_alu_flag_up;
  assign w_fwd     = FWD & w_flag_wr;

`ifdef FLAG_SAVE_EN
  logic [4:0] r_shadow;
  logic [4:0] w_sel_flags;

  // Save captures what a branch would have seen this cycle (forwarded or stored).
  assign w_sel_flags = w_fwd ? i_alu_flags : r_flags;
  // A restore overrides everything, so evaluation follows the shadow copy.
  assign w_eval      = i_flag_restore ? r_shadow[4:1] : w_sel_flags[4:1];

  // Flag register: restore beats an ALU write in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= FLAGS_RST;
    end else if (i_flag_restore) begin
      r_flags <= r_shadow;
    end else if (w_flag_wr) begin
      r_flags <= i_alu_flags;
    end
  end

  // Shadow register; save together with restore swaps the two copies
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= FLAGS_RST;
    end else if (i_flag_save) begin
      r_shadow <= w_sel_flags;
    end
  end
`else
  assign w_eval = w_fwd ? i_alu_flags[4:1] : r_flags[4:1];

  // Flag register: load from the ALU when it writes flags, else hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= FLAGS_RST;
    end else if (w_flag_wr) begin
      r_flags <= i_alu_flags;
    end
  end
`endif

  // Condition decode; f = {sf,zf,cf,vf}
  function automatic logic f_cond(input logic [3:0] c, input logic [3:0] f);
    logic sf, zf, cf, vf;
    logic r;
    sf = f[3];
    zf = f[2];
    cf = f[1];
    vf = f[0];
    case (c)
      4'd0:    r = zf;
      4'd1:    r = ~zf;
      4'd2:    r = sf ^ vf;
      4'd3:    r = ~(sf ^ vf);
      4'd4:    r = zf | (sf ^ vf);
      4'd5:    r = ~zf & ~(sf ^ vf);
      4'd6:    r = cf;
      4'd7:    r = ~cf;
      4'd8:    r = sf;
      4'd9:    r = ~sf;
      4'd10:   r = vf;
      4'd11:   r = ~vf;
      4'd12:   r = ~cf & ~zf;
      4'd13:   r = cf | zf;
      4'd14:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign w_taken    = f_cond(i_br_cond, w_eval);
  assign w_br_ready = (r_state == S_EMPTY) | i_res_ready;
  assign w_accept   = i_br_valid & w_br_ready;

  // Stage state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and payload-load decision
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = S_FULL;
          w_load      = 1'b1;
        end
      end
      S_FULL: begin
        if (i_res_ready) begin
          if (w_accept) begin
            w_state_nxt = S_FULL;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_EMPTY;
          end
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  // Resolution payload; holds its value once consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_taken  <= 1'b0;
      r_res_target <= '0;
    end else if (w_load) begin
      r_res_taken  <= w_taken;
      r_res_target <= i_br_target;
    end
  end

  assign o_br_ready   = w_br_ready;
  assign o_res_valid  = (r_state == S_FULL);
  assign o_res_taken  = r_res_taken;
  assign o_res_target = r_res_target;
  assign o_flags_out  = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_flag_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flag_branch_unit
//  Brief    : Directed, table-driven self-checking bench for flag_branch_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_flag_branch_unit;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid, alu_flag_up;
  logic [4:0]        alu_flags;
  logic              br_valid;
  logic [3:0]        br_cond;
  logic [ADDR_W-1:0] br_target;
  logic              res_ready;
  logic              flag_save, flag_restore;

  logic              br_ready, res_valid, res_taken;
  logic [ADDR_W-1:0] res_target;
  logic [4:0]        flags_out;

  logic              nf_br_ready, nf_res_valid, nf_res_taken;
  logic [ADDR_W-1:0] nf_res_target;
  logic [4:0]        nf_flags_out;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  flag_branch_unit #(.ADDR_W(ADDR_W), .FLAGS_RST(5'b0), .FWD(1'b1)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_alu_valid  (alu_valid),
    .i_alu_flag_up(alu_flag_up),
    .i_alu_flags  (alu_flags),
    .i_br_valid   (br_valid),
    .o_br_ready   (br_ready),
    .i_br_cond    (br_cond),
    .i_br_target  (br_target),
    .o_res_valid  (res_valid),
    .i_res_ready  (res_ready),
    .o_res_taken  (res_taken),
    .o_res_target (res_target),
`ifdef FLAG_SAVE_EN
    .i_flag_save   (flag_save),
    .i_flag_restore(flag_restore),
`endif
    .o_flags_out  (flags_out)
  );

  // Second instance without forwarding, sharing all inputs
  flag_branch_unit #(.ADDR_W(ADDR_W), .FLAGS_RST(5'b0), .FWD(1'b0)) u_dut_nf (
    .clk          (clk),
    .rst          (rst),
    .i_alu_valid  (alu_valid),
    .i_alu_flag_up(alu_flag_up),
    .i_alu_flags  (alu_flags),
    .i_br_valid   (br_valid),
    .o_br_ready   (nf_br_ready),
    .i_br_cond    (br_cond),
    .i_br_target  (br_target),
    .o_res_valid  (nf_res_valid),
    .i_res_ready  (res_ready),
    .o_res_taken  (nf_res_taken),
    .o_res_target (nf_res_target),
`ifdef FLAG_SAVE_EN
    .i_flag_save   (flag_save),
    .i_flag_restore(flag_restore),
`endif
    .o_flags_out  (nf_flags_out)
  );

  typedef struct {
    logic [4:0]  flags;
    logic [3:0]  cond;
    logic [31:0] target;
    logic        exp_taken;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid    = 1'b0;
    alu_flag_up  = 1'b0;
    alu_flags    = 5'b0;
    br_valid     = 1'b0;
    br_cond      = 4'd0;
    br_target    = '0;
    flag_save    = 1'b0;
    flag_restore = 1'b0;
  endtask

  task automatic write_flags(input logic [4:0] f);
    alu_valid   = 1'b1;
    alu_flag_up = 1'b1;
    alu_flags   = f;
    tick();
    alu_valid   = 1'b0;
    alu_flag_up = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_pat;

    // {flags {sf,zf,cf,vf,pf}, cond, target, expected taken}
    vecs[0]  = '{5'b01000, 4'd0,  32'h0000_0100, 1'b1};  // EQ, zf
    vecs[1]  = '{5'b01000, 4'd1,  32'h0000_0104, 1'b0};  // NE
    vecs[2]  = '{5'b01000, 4'd4,  32'h0000_0108, 1'b1};  // LE
    vecs[3]  = '{5'b01000, 4'd5,  32'h0000_010C, 1'b0};  // GT
    vecs[4]  = '{5'b01000, 4'd12, 32'h0000_0110, 1'b0};  // HI
    vecs[5]  = '{5'b01000, 4'd13, 32'h0000_0114, 1'b1};  // LS
    vecs[6]  = '{5'b10000, 4'd2,  32'h0000_0200, 1'b1};  // LT, sf
    vecs[7]  = '{5'b10000, 4'd3,  32'h0000_0204, 1'b0};  // GE
    vecs[8]  = '{5'b10000, 4'd8,  32'h0000_0208, 1'b1};  // MI
    vecs[9]  = '{5'b10000, 4'd9,  32'h0000_020C, 1'b0};  // PL
    vecs[10] = '{5'b10000, 4'd4,  32'h0000_0210, 1'b1};  // LE
    vecs[11] = '{5'b10000, 4'd5,  32'h0000_0214, 1'b0};  // GT
    vecs[12] = '{5'b10010, 4'd2,  32'h0000_0300, 1'b0};  // LT, sf=vf
    vecs[13] = '{5'b10010, 4'd3,  32'h0000_0304, 1'b1};  // GE
    vecs[14] = '{5'b10010, 4'd5,  32'h0000_0308, 1'b1};  // GT
    vecs[15] = '{5'b10010, 4'd10, 32'h0000_030C, 1'b1};  // VS
    vecs[16] = '{5'b10010, 4'd11, 32'h0000_0310, 1'b0};  // VC
    vecs[17] = '{5'b00010, 4'd2,  32'h0000_0400, 1'b1};  // LT, vf only
    vecs[18] = '{5'b00010, 4'd4,  32'h0000_0404, 1'b1};  // LE
    vecs[19] = '{5'b00001, 4'd0,  32'h0000_0500, 1'b0};  // EQ, pf only
    vecs[20] = '{5'b00001, 4'd1,  32'h0000_0504, 1'b1};  // NE
    vecs[21] = '{5'b00001, 4'd6,  32'h0000_0508, 1'b0};  // CS
    vecs[22] = '{5'b00001, 4'd14, 32'h0000_050C, 1'b1};  // AL
    vecs[23] = '{5'b00001, 4'd15, 32'h8000_0000, 1'b0};  // NV

    // Taken pattern for conds 15..0 with cf=1, all other flags clear
    exp_pat = 16'h6A6A;

    idle_inputs();
    res_ready = 1'b1;
    rst       = 1'b1;
    #2;
    check("rst_flags",      {27'd0, flags_out}, 32'h0);
    check("rst_res_valid",  {31'd0, res_valid}, 32'h0);
    check("rst_res_taken",  {31'd0, res_taken}, 32'h0);
    check("rst_res_target", res_target,         32'h0);
    tick();
    tick();
    rst = 1'b0;
    check("rst_br_ready",   {31'd0, br_ready},  32'h1);

    // Table: write flags, branch next cycle, result one cycle later
    for (int i = 0; i < 24; i++) begin
      write_flags(vecs[i].flags);
      br_valid  = 1'b1;
      br_cond   = vecs[i].cond;
      br_target = vecs[i].target;
      check($sformatf("vec%0d_br_ready", i), {31'd0, br_ready}, 32'h1);
      tick();
      br_valid = 1'b0;
      check($sformatf("vec%0d_res_valid", i), {31'd0, res_valid}, 32'h1);
      check($sformatf("vec%0d_taken", i),     {31'd0, res_taken}, {31'd0, vecs[i].exp_taken});
      check($sformatf("vec%0d_target", i),    res_target,         vecs[i].target);
      check($sformatf("vec%0d_flags", i),     {27'd0, flags_out}, {27'd0, vecs[i].flags});
      tick();
      check($sformatf("vec%0d_drain", i),     {31'd0, res_valid}, 32'h0);
    end

    // Same-cycle flag write and LT: forwarding sees sf=1, non-forwarding sees 0
    write_flags(5'b00000);
    alu_valid   = 1'b1;
    alu_flag_up = 1'b1;
    alu_flags   = 5'b10000;
    br_valid    = 1'b1;
    br_cond     = 4'd2;
    br_target   = 32'h0000_0600;
    tick();
    idle_inputs();
    check("fwd_taken",     {31'd0, res_taken},    32'h1);
    check("nofwd_taken",   {31'd0, nf_res_taken}, 32'h0);
    check("nofwd_valid",   {31'd0, nf_res_valid}, 32'h1);
    check("fwd_flags",     {27'd0, flags_out},    32'h10);
    tick();

    // Backpressure: first result stalls 3 cycles, second branch waits
    res_ready = 1'b0;
    br_valid  = 1'b1;
    br_cond   = 4'd14;
    br_target = 32'h0000_0A10;
    tick();
    br_cond   = 4'd15;
    br_target = 32'h0000_0A20;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        alu_valid   = 1'b1;
        alu_flag_up = 1'b1;
        alu_flags   = 5'b01100;
      end else begin
        alu_valid   = 1'b0;
        alu_flag_up = 1'b0;
      end
      check($sformatf("stall%0d_br_ready", c), {31'd0, br_ready},  32'h0);
      check($sformatf("stall%0d_valid", c),    {31'd0, res_valid}, 32'h1);
      check($sformatf("stall%0d_taken", c),    {31'd0, res_taken}, 32'h1);
      check($sformatf("stall%0d_target", c),   res_target,         32'h0000_0A10);
      tick();
    end
    check("stall_flag_write", {27'd0, flags_out}, 32'h0C);
    res_ready = 1'b1;
    #1;
    check("unstall_br_ready", {31'd0, br_ready}, 32'h1);
    tick();
    br_valid = 1'b0;
    check("second_valid",  {31'd0, res_valid}, 32'h1);
    check("second_taken",  {31'd0, res_taken}, 32'h0);
    check("second_target", res_target,         32'h0000_0A20);
    tick();
    check("second_drain",  {31'd0, res_valid}, 32'h0);
    check("hold_target",   res_target,         32'h0000_0A20);

    // Back-to-back: all 16 conditions, one result per cycle, cf=1 only
    write_flags(5'b00100);
    for (int i = 0; i < 16; i++) begin
      br_valid  = 1'b1;
      br_cond   = 4'(i);
      br_target = 32'h0000_0700 + 32'(i);
      check($sformatf("b2b%0d_br_ready", i), {31'd0, br_ready}, 32'h1);
      tick();
      check($sformatf("b2b%0d_valid", i),  {31'd0, res_valid}, 32'h1);
      check($sformatf("b2b%0d_taken", i),  {31'd0, res_taken}, {31'd0, exp_pat[i]});
      check($sformatf("b2b%0d_target", i), res_target,         32'h0000_0700 + 32'(i));
    end
    br_valid = 1'b0;
    tick();
    check("b2b_drain", {31'd0, res_valid}, 32'h0);

`ifdef FLAG_SAVE_EN
    // Save 10000, overwrite, then restore while the ALU writes
    write_flags(5'b10000);
    flag_save = 1'b1;
    tick();
    flag_save = 1'b0;
    write_flags(5'b00100);
    check("save_alu_flags", {27'd0, flags_out}, 32'h04);
    flag_restore = 1'b1;
    alu_valid    = 1'b1;
    alu_flag_up  = 1'b1;
    alu_flags    = 5'b01000;
    br_valid     = 1'b1;
    br_cond      = 4'd8;
    br_target    = 32'h0000_0900;
    tick();
    idle_inputs();
    check("restore_flags", {27'd0, flags_out}, 32'h10);
    check("restore_taken", {31'd0, res_taken}, 32'h1);
    tick();
`endif

    // Reset mid-operation with a pending resolution and non-zero flags
    write_flags(5'b11111);
    res_ready = 1'b0;
    br_valid  = 1'b1;
    br_cond   = 4'd14;
    br_target = 32'h0000_0B00;
    tick();
    br_valid = 1'b0;
    check("pre_rst_valid", {31'd0, res_valid}, 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_flags",  {27'd0, flags_out}, 32'h0);
    check("mid_rst_valid",  {31'd0, res_valid}, 32'h0);
    check("mid_rst_target", res_target,         32'h0);
    tick();
    rst       = 1'b0;
    res_ready = 1'b1;
    tick();
    check("post_rst_valid",    {31'd0, res_valid}, 32'h0);
    check("post_rst_br_ready", {31'd0, br_ready},  32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
